// File: rtl/floppy_pkg.sv
// Shared types and default timing for the IEC-to-Shugart floppy bridge.
package floppy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPINUP   = 3'd1,
    ST_SEEK0    = 3'd2,
    ST_WAIT_IDX = 3'd3,
    ST_READY    = 3'd4,
    ST_ERROR    = 3'd5
  } fsm_state_e;

  localparam int unsigned SPINUP_CYC_DEF        = 25_000_000;
  localparam int unsigned STEP_PULSE_CYC_DEF    = 1_000;
  localparam int unsigned STEP_PERIOD_CYC_DEF   = 1_500_000;
  localparam int unsigned MAX_STEPS_DEF         = 90;
  localparam int unsigned INDEX_TIMEOUT_CYC_DEF = 200_000_000;

  // ACTION_LED in ERROR flips each time the low ERR_BLINK_BIT timer bits wrap.
  localparam int unsigned ERR_BLINK_BIT = 24;

endpackage

// File: rtl/iec_floppy_ctrl_sync_edge.sv
// Two-flop synchroniser with a one-cycle rising-edge pulse behind it.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/iec_floppy_ctrl.sv
// Bring-up controller: spins drive A, seeks to track 0, then watches INDEX.
// The IEC side only acknowledges ATN; the floppy write path is never driven.
module iec_floppy_ctrl
  import floppy_pkg::*;
#(
  parameter int unsigned SPINUP_CYC        = SPINUP_CYC_DEF,
  parameter int unsigned STEP_PULSE_CYC    = STEP_PULSE_CYC_DEF,
  parameter int unsigned STEP_PERIOD_CYC   = STEP_PERIOD_CYC_DEF,
  parameter int unsigned MAX_STEPS         = MAX_STEPS_DEF,
  parameter int unsigned INDEX_TIMEOUT_CYC = INDEX_TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       RESET_IN,
  input  logic       ATN_IN,
  input  logic       CLK_IN,
  input  logic       DATA_IN,
  input  logic       SRQ_IN,
  output logic       CLK_OUT,
  output logic       DATA_OUT,
  output logic       SRQ_OUT,
  input  logic       DSKCHG,
  input  logic       RDATA,
  input  logic       WPT,
  input  logic       TRK00,
  input  logic       INDEX,
  input  logic       REDWC_IN,
  output logic       SIDE1,
  output logic       WGATE,
  output logic       WDATE,
  output logic       STEP,
  output logic       DIR,
  output logic       MOTEA,
  output logic       MOTEB,
  output logic       DRVSA,
  output logic       DRVSB,
  output logic       REDWC_OUT,
  input  logic       SW0,
  input  logic       SW1,
  output logic       PWR_LED,
  output logic       ACTION_LED,
  output fsm_state_e dbg_state_o
);

  localparam int IN_ATN   = 0;
  localparam int IN_TRK00 = 7;
  localparam int IN_INDEX = 8;
  localparam int IN_SW0   = 10;
  localparam int IN_SW1   = 11;
  localparam int NUM_IN   = 12;

  logic [NUM_IN-1:0] pins;
  logic [NUM_IN-1:0] sync_v;
  logic [NUM_IN-1:0] rise_v;
  logic              unused_in;

  assign pins = {SW1, SW0, REDWC_IN, INDEX, TRK00, WPT, RDATA, DSKCHG,
                 SRQ_IN, DATA_IN, CLK_IN, ATN_IN};

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sync
    sync_edge u_sync (
      .clk    (clk),
      .rst_n  (RESET_IN),
      .d_i    (pins[gi]),
      .sync_o (sync_v[gi]),
      .rise_o (rise_v[gi])
    );
  end

  // Bus and status lines this read-only bring-up never looks at.
  assign unused_in = ^{sync_v, rise_v};

  logic trk00_s;
  logic idx_rise;
  assign trk00_s  = sync_v[IN_TRK00];
  assign idx_rise = rise_v[IN_INDEX];

  fsm_state_e  state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [31:0] step_cnt_q, step_cnt_d;
  logic        step_q, step_d;
  logic        act_q, act_d;
  logic        pwr_q;

  always_ff @(posedge clk or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      step_cnt_q <= '0;
      step_q     <= 1'b0;
      act_q      <= 1'b0;
      pwr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      step_cnt_q <= step_cnt_d;
      step_q     <= step_d;
      act_q      <= act_d;
      pwr_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q + 32'd1;
    step_cnt_d = step_cnt_q;
    step_d     = step_q;
    act_d      = act_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SPINUP;
        tmr_d   = '0;
        act_d   = 1'b1;
      end
      ST_SPINUP: begin
        if (tmr_q == SPINUP_CYC - 1) begin
          state_d = ST_SEEK0;
          tmr_d   = '0;
        end
      end
      ST_SEEK0: begin
        if (tmr_q == STEP_PULSE_CYC) step_d = 1'b0;
        // Step boundary: seek entry (timer 0) or end of a full step period.
        if (tmr_q == '0 || tmr_q == STEP_PERIOD_CYC) begin
          if (trk00_s) begin
            state_d = ST_WAIT_IDX;
            tmr_d   = '0;
            act_d   = 1'b0;
          end else if (step_cnt_q == MAX_STEPS) begin
            state_d = ST_ERROR;
            tmr_d   = '0;
          end else begin
            step_d     = 1'b1;
            step_cnt_d = step_cnt_q + 32'd1;
            tmr_d      = 32'd1;
          end
        end
      end
      ST_WAIT_IDX: begin
        if (idx_rise) begin
          state_d = ST_READY;
          tmr_d   = '0;
        end else if (tmr_q == INDEX_TIMEOUT_CYC - 1) begin
          state_d = ST_ERROR;
          tmr_d   = '0;
        end
      end
      ST_READY: begin
        if (idx_rise) begin
          act_d = ~act_q;
          tmr_d = '0;
        end else if (tmr_q == INDEX_TIMEOUT_CYC - 1) begin
          state_d = ST_ERROR;
          tmr_d   = '0;
        end
      end
      ST_ERROR: begin
        if (tmr_q[ERR_BLINK_BIT-1:0] == '1) act_d = ~act_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dbg_state_o = state_q;

  assign MOTEA      = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign DRVSA      = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign STEP       = step_q;
  assign DIR        = 1'b0;
  assign ACTION_LED = act_q;
  assign PWR_LED    = pwr_q;

  assign WGATE = 1'b0;
  assign WDATE = 1'b0;
  assign MOTEB = 1'b0;
  assign DRVSB = 1'b0;

  assign SIDE1     = sync_v[IN_SW1];
  assign REDWC_OUT = sync_v[IN_SW0];

  assign DATA_OUT = sync_v[IN_ATN];
  assign CLK_OUT  = 1'b0;
  assign SRQ_OUT  = 1'b0;

endmodule

// File: tb/tb_iec_floppy_ctrl.sv
// Self-checking bench for iec_floppy_ctrl with shortened timing parameters.
module tb_iec_floppy_ctrl;
  import floppy_pkg::*;

  localparam int unsigned T_SPINUP  = 100;
  localparam int unsigned T_PULSE   = 5;
  localparam int unsigned T_PERIOD  = 20;
  localparam int unsigned T_MAXSTEP = 4;
  localparam int unsigned T_TIMEOUT = 300;

  logic clk = 1'b0;
  logic RESET_IN = 1'b0;
  logic ATN_IN = 0, CLK_IN = 0, DATA_IN = 0, SRQ_IN = 0;
  logic DSKCHG = 0, RDATA = 0, WPT = 0, TRK00 = 0, INDEX = 0, REDWC_IN = 0;
  logic SW0 = 0, SW1 = 0;
  logic CLK_OUT, DATA_OUT, SRQ_OUT, SIDE1, WGATE, WDATE, STEP, DIR;
  logic MOTEA, MOTEB, DRVSA, DRVSB, REDWC_OUT, PWR_LED, ACTION_LED;
  fsm_state_e dbg_state;

  iec_floppy_ctrl #(
    .SPINUP_CYC        (T_SPINUP),
    .STEP_PULSE_CYC    (T_PULSE),
    .STEP_PERIOD_CYC   (T_PERIOD),
    .MAX_STEPS         (T_MAXSTEP),
    .INDEX_TIMEOUT_CYC (T_TIMEOUT)
  ) dut (
    .clk(clk), .RESET_IN(RESET_IN),
    .ATN_IN(ATN_IN), .CLK_IN(CLK_IN), .DATA_IN(DATA_IN), .SRQ_IN(SRQ_IN),
    .CLK_OUT(CLK_OUT), .DATA_OUT(DATA_OUT), .SRQ_OUT(SRQ_OUT),
    .DSKCHG(DSKCHG), .RDATA(RDATA), .WPT(WPT), .TRK00(TRK00), .INDEX(INDEX),
    .REDWC_IN(REDWC_IN), .SIDE1(SIDE1), .WGATE(WGATE), .WDATE(WDATE),
    .STEP(STEP), .DIR(DIR), .MOTEA(MOTEA), .MOTEB(MOTEB), .DRVSA(DRVSA),
    .DRVSB(DRVSB), .REDWC_OUT(REDWC_OUT), .SW0(SW0), .SW1(SW1),
    .PWR_LED(PWR_LED), .ACTION_LED(ACTION_LED), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [14:0] all_outs;
  assign all_outs = {CLK_OUT, DATA_OUT, SRQ_OUT, SIDE1, WGATE, WDATE, STEP, DIR,
                     MOTEA, MOTEB, DRVSA, DRVSB, REDWC_OUT, PWR_LED, ACTION_LED};

  // ---------------- STEP monitor ----------------
  int steps = 0;
  int hi_len = 0;
  int since_rise = 0;
  logic step_prev = 1'b0;
  logic dir_seen = 1'b0;

  always @(negedge clk) begin
    if (!RESET_IN) begin
      step_prev  = 1'b0;
      hi_len     = 0;
      since_rise = 0;
    end else begin
      if (STEP) hi_len++;
      if (DIR) dir_seen = 1'b1;
      since_rise++;
      if (STEP && !step_prev) begin
        steps++;
        if (steps > 1) check("step_period", since_rise, T_PERIOD);
        since_rise = 0;
      end
      if (!STEP && step_prev) begin
        check("step_width", hi_len, T_PULSE);
        hi_len = 0;
      end
      step_prev = STEP;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input logic trk);
    RESET_IN = 1'b0;
    TRK00 = trk;
    INDEX = 1'b0;
    ATN_IN = 1'b0;
    SW0 = 1'b0;
    SW1 = 1'b0;
    repeat (5) tick();
    steps = 0;
    dir_seen = 1'b0;
    RESET_IN = 1'b1;
  endtask

  task automatic wait_state(input string name, input fsm_state_e st, input int budget,
                            output int n);
    n = 0;
    while (dbg_state != st && n < budget) begin
      tick();
      n++;
    end
    check(name, dbg_state, st);
  endtask

  task automatic index_pulse(input int hi, input int lo);
    INDEX = 1'b1;
    repeat (hi) tick();
    INDEX = 1'b0;
    repeat (lo) tick();
  endtask

  // ---------------- scoreboard ----------------
  logic exp_q[$];

  // DATA_OUT must reproduce the ATN pin two cycles later.
  task automatic atn_step(input logic v);
    ATN_IN = v;
    exp_q.push_back(v);
    tick();
    if (exp_q.size() == 2) check("data_out_ack", DATA_OUT, exp_q.pop_front());
  endtask

  int ready_edges = 0;

  task automatic ready_pulse(input int hi, input int lo);
    index_pulse(hi, lo);
    ready_edges++;
    check("action_led_parity", ACTION_LED, 32'(ready_edges % 2));
    check("ready_hold", dbg_state, ST_READY);
  endtask

  typedef struct {
    logic sw0;
    logic sw1;
    logic atn;
    logic exp_redwc;
    logic exp_side1;
    logic exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    int total;
    logic [9:0] atn_pat;

    tbl[0] = '{sw0:0, sw1:0, atn:0, exp_redwc:0, exp_side1:0, exp_data:0};
    tbl[1] = '{sw0:1, sw1:0, atn:0, exp_redwc:1, exp_side1:0, exp_data:0};
    tbl[2] = '{sw0:0, sw1:1, atn:1, exp_redwc:0, exp_side1:1, exp_data:1};
    tbl[3] = '{sw0:1, sw1:1, atn:1, exp_redwc:1, exp_side1:1, exp_data:1};
    tbl[4] = '{sw0:1, sw1:1, atn:0, exp_redwc:1, exp_side1:1, exp_data:0};
    tbl[5] = '{sw0:0, sw1:0, atn:1, exp_redwc:0, exp_side1:0, exp_data:1};

    // Reset hold with active inputs: every output stays low.
    RESET_IN = 1'b0;
    TRK00 = 1'b1;
    ATN_IN = 1'b1;
    SW0 = 1'b1;
    SW1 = 1'b1;
    repeat (50) tick();
    check("reset_outputs", 32'(all_outs), 0);
    check("reset_state", dbg_state, ST_IDLE);
    ATN_IN = 1'b0;
    SW0 = 1'b0;
    SW1 = 1'b0;
    repeat (3) tick();

    // Release; drive select comes on in the second cycle.
    RESET_IN = 1'b1;
    #1;
    check("drvsa_first_cycle", DRVSA, 0);
    check("motea_first_cycle", MOTEA, 0);
    tick();
    check("drvsa_on", DRVSA, 1);
    check("motea_on", MOTEA, 1);
    check("pwr_led_on", PWR_LED, 1);
    check("action_led_spinup", ACTION_LED, 1);

    // TRK00 already asserted: no steps, WAIT_IDX after roughly SPINUP_CYC.
    wait_state("reach_wait_idx", ST_WAIT_IDX, 200, n);
    total = n + 1;
    check("wait_idx_latency_ok", 32'(total >= 100 && total <= 104), 1);
    check("no_steps_at_trk00", steps, 0);
    check("action_led_wait", ACTION_LED, 0);

    // Switch / ATN table.
    for (int i = 0; i < 6; i++) begin
      SW0 = tbl[i].sw0;
      SW1 = tbl[i].sw1;
      ATN_IN = tbl[i].atn;
      repeat (2) tick();
      check("tbl_redwc", REDWC_OUT, tbl[i].exp_redwc);
      check("tbl_side1", SIDE1, tbl[i].exp_side1);
      check("tbl_data", DATA_OUT, tbl[i].exp_data);
      check("tbl_static", 32'({CLK_OUT, SRQ_OUT, WGATE, WDATE, MOTEB, DRVSB, DIR}), 0);
    end
    ATN_IN = 1'b0;
    SW0 = 1'b0;
    SW1 = 1'b0;
    repeat (3) tick();

    // Four-cycle ATN pulse, then random ATN traffic.
    exp_q.delete();
    atn_pat = 10'b0000011110;
    for (int i = 0; i < 10; i++) atn_step(atn_pat[i]);
    for (int i = 0; i < 40; i++) atn_step(1'($urandom_range(0, 1)));
    ATN_IN = 1'b0;
    exp_q.delete();

    // First INDEX edge enters READY without toggling the LED.
    index_pulse(3, 3);
    check("enter_ready", dbg_state, ST_READY);
    check("ready_led_start", ACTION_LED, 0);
    ready_edges = 0;
    for (int i = 0; i < 6; i++) ready_pulse(5, 5);
    for (int i = 0; i < 5; i++) ready_pulse(3, 3);
    check("led_after_11", ACTION_LED, 1);
    for (int i = 0; i < 4; i++) ready_pulse(2, 2);
    for (int i = 0; i < 12; i++) ready_pulse($urandom_range(2, 6), $urandom_range(2, 6));

    // INDEX stops: READY holds until the timeout, then ERROR.
    repeat (250) tick();
    check("ready_before_timeout", dbg_state, ST_READY);
    wait_state("ready_timeout_error", ST_ERROR, 100, n);
    check("error_motea", MOTEA, 0);
    check("error_drvsa", DRVSA, 0);
    check("error_step", STEP, 0);

    // Seek with TRK00 arriving after the third step; INDEX ignored in SPINUP.
    apply_reset(1'b0);
    repeat (20) tick();
    index_pulse(3, 3);
    index_pulse(3, 3);
    check("spinup_ignores_index", dbg_state, ST_SPINUP);
    check("spinup_led", ACTION_LED, 1);
    n = 0;
    while (!(steps == 3 && !STEP) && n < 400) begin
      tick();
      n++;
    end
    check("third_step_seen", steps, 3);
    TRK00 = 1'b1;
    wait_state("seek_to_wait_idx", ST_WAIT_IDX, 100, n);
    check("seek_step_count", steps, 3);
    check("dir_outward", dir_seen, 0);
    check("led_wait_after_seek", ACTION_LED, 0);

    // No TRK00 at all: MAX_STEPS steps, then ERROR.
    apply_reset(1'b0);
    wait_state("seek_error", ST_ERROR, 500, n);
    check("max_steps_issued", steps, T_MAXSTEP);
    check("seek_err_motea", MOTEA, 0);
    check("seek_err_drvsa", DRVSA, 0);

    // Asynchronous reset in the middle of a STEP pulse.
    apply_reset(1'b0);
    n = 0;
    while (!STEP && n < 300) begin
      tick();
      n++;
    end
    check("step_high_before_reset", STEP, 1);
    #3;
    RESET_IN = 1'b0;
    #1;
    check("async_reset_step", STEP, 0);
    check("async_reset_outputs", 32'(all_outs), 0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
